// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: arms on enable, rings on a fresh alarm-time match,
// and handles stop, snooze (limited per alarm event) and ring auto-timeout.
module alarm_ring_ctrl #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        one_second,
    input  logic [15:0] alarm_time,
    input  logic [15:0] current_time,
    input  logic        alarm_enable,
    input  logic        stop_button,
    input  logic        snooze_button,
    output logic        sound_alarm,
    output logic        snoozing,
    output logic        ring_start,
    output logic [1:0]  snooze_cnt
);

    localparam int unsigned SEC_W = 9;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEC_W-1:0]   sec_cnt;
    logic [SEC_W-1:0]   sec_cnt_nxt;
    logic [CNT_W-1:0]   snooze_cnt_nxt;
    logic               match;
    logic               match_d;
    logic               match_rise;
    logic               stop_d;
    logic               snooze_d;
    logic               stop_edge;
    logic               snooze_edge;
    logic               ring_last;
    logic               snooze_last;
    logic               snooze_avail;

    assign match        = (current_time == alarm_time);
    assign match_rise   = match & ~match_d;
    assign stop_edge    = stop_button & ~stop_d;
    assign snooze_edge  = snooze_button & ~snooze_d;
    assign ring_last    = (sec_cnt == SEC_W'(RING_SECS - 1));
    assign snooze_last  = (sec_cnt == SEC_W'(SNOOZE_SECS - 1));
    assign snooze_avail = (snooze_cnt < CNT_W'(MAX_SNOOZE));

    // Next-state and counter updates; disable overrides everything.
    always_comb begin
        state_nxt      = state;
        sec_cnt_nxt    = sec_cnt;
        snooze_cnt_nxt = snooze_cnt;
        if (!alarm_enable) begin
            state_nxt      = IDLE;
            sec_cnt_nxt    = '0;
            snooze_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt      = ARMED;
                    sec_cnt_nxt    = '0;
                    snooze_cnt_nxt = '0;
                end
                ARMED: begin
                    if (match_rise) begin
                        state_nxt   = RINGING;
                        sec_cnt_nxt = '0;
                    end
                end
                RINGING: begin
                    if (stop_edge) begin
                        state_nxt      = ARMED;
                        sec_cnt_nxt    = '0;
                        snooze_cnt_nxt = '0;
                    end else if (snooze_edge && snooze_avail) begin
                        state_nxt      = SNOOZE;
                        sec_cnt_nxt    = '0;
                        snooze_cnt_nxt = snooze_cnt + 1'b1;
                    end else if (one_second) begin
                        if (ring_last) begin
                            state_nxt      = ARMED;
                            sec_cnt_nxt    = '0;
                            snooze_cnt_nxt = '0;
                        end else begin
                            sec_cnt_nxt = sec_cnt + 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_edge) begin
                        state_nxt      = ARMED;
                        sec_cnt_nxt    = '0;
                        snooze_cnt_nxt = '0;
                    end else if (one_second) begin
                        if (snooze_last) begin
                            state_nxt   = RINGING;
                            sec_cnt_nxt = '0;
                        end else begin
                            sec_cnt_nxt = sec_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt      = IDLE;
                    sec_cnt_nxt    = '0;
                    snooze_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State, counters, edge-detect history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            snooze_cnt  <= '0;
            match_d     <= 1'b0;
            stop_d      <= 1'b0;
            snooze_d    <= 1'b0;
            sound_alarm <= 1'b0;
            snoozing    <= 1'b0;
            ring_start  <= 1'b0;
        end else begin
            state       <= state_nxt;
            sec_cnt     <= sec_cnt_nxt;
            snooze_cnt  <= snooze_cnt_nxt;
            match_d     <= match;
            stop_d      <= stop_button;
            snooze_d    <= snooze_button;
            sound_alarm <= (state_nxt == RINGING);
            snoozing    <= (state_nxt == SNOOZE);
            ring_start  <= (state_nxt == RINGING) && (state != RINGING);
        end
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with default parameters.
module tb_alarm_ring_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        one_second;
    logic [15:0] alarm_time;
    logic [15:0] current_time;
    logic        alarm_enable;
    logic        stop_button;
    logic        snooze_button;
    logic        sound_alarm;
    logic        snoozing;
    logic        ring_start;
    logic [1:0]  snooze_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_ring_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .one_second   (one_second),
        .alarm_time   (alarm_time),
        .current_time (current_time),
        .alarm_enable (alarm_enable),
        .stop_button  (stop_button),
        .snooze_button(snooze_button),
        .sound_alarm  (sound_alarm),
        .snoozing     (snoozing),
        .ring_start   (ring_start),
        .snooze_cnt   (snooze_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            one_second = 1'b1;
            step();
            one_second = 1'b0;
            step();
        end
    endtask

    // Step the time off and back onto the alarm time to fire a fresh match.
    task automatic start_ring();
        current_time = 16'h0731;
        step();
        current_time = 16'h0730;
        step();
    endtask

    task automatic press_stop();
        stop_button = 1'b1;
        step();
        stop_button = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        one_second = 1'b0;
        alarm_time = 16'h0730;
        current_time = 16'h0000;
        alarm_enable = 1'b0;
        stop_button = 1'b0;
        snooze_button = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sound_alarm, snoozing, ring_start, snooze_cnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 00000", {sound_alarm, snoozing, ring_start, snooze_cnt});
        end
        rst_n = 1'b1;
        alarm_enable = 1'b1;
        step();
        step();
    endtask

    task automatic test_match_ring();
        current_time = 16'h0729;
        step();
        current_time = 16'h0730;
        step();
        n_checks++;
        if (sound_alarm !== 1'b1 || ring_start !== 1'b1 || snoozing !== 1'b0) begin
            n_fail++;
            $display("FAIL match_ring: sound=%b start=%b snz=%b, expected 1 1 0", sound_alarm, ring_start, snoozing);
        end
        step();
        n_checks++;
        if (sound_alarm !== 1'b1 || ring_start !== 1'b0) begin
            n_fail++;
            $display("FAIL ring_start_width: sound=%b start=%b, expected 1 0", sound_alarm, ring_start);
        end
    endtask

    task automatic test_auto_stop();
        pulses(59);
        n_checks++;
        if (sound_alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL ring_before_timeout: sound=%b, expected 1", sound_alarm);
        end
        pulses(1);
        n_checks++;
        if (sound_alarm !== 1'b0 || snooze_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL ring_timeout: sound=%b cnt=%0d, expected 0 0", sound_alarm, snooze_cnt);
        end
    endtask

    task automatic test_snooze_sequence();
        start_ring();
        for (int k = 1; k <= 3; k++) begin
            snooze_button = 1'b1;
            step();
            n_checks++;
            if (snoozing !== 1'b1 || sound_alarm !== 1'b0 || snooze_cnt !== 2'(k)) begin
                n_fail++;
                $display("FAIL snooze_enter_%0d: snz=%b sound=%b cnt=%0d, expected 1 0 %0d", k, snoozing, sound_alarm, snooze_cnt, k);
            end
            snooze_button = 1'b0;
            step();
            pulses(299);
            n_checks++;
            if (snoozing !== 1'b1) begin
                n_fail++;
                $display("FAIL snooze_hold_%0d: snz=%b, expected 1", k, snoozing);
            end
            one_second = 1'b1;
            step();
            n_checks++;
            if (sound_alarm !== 1'b1 || ring_start !== 1'b1 || snooze_cnt !== 2'(k)) begin
                n_fail++;
                $display("FAIL rering_%0d: sound=%b start=%b cnt=%0d, expected 1 1 %0d", k, sound_alarm, ring_start, snooze_cnt, k);
            end
            one_second = 1'b0;
            step();
        end
        snooze_button = 1'b1;
        step();
        n_checks++;
        if (sound_alarm !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL fourth_snooze: sound=%b snz=%b cnt=%0d, expected 1 0 3", sound_alarm, snoozing, snooze_cnt);
        end
        snooze_button = 1'b0;
        step();
        press_stop();
        n_checks++;
        if (sound_alarm !== 1'b0 || snooze_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL stop_after_max: sound=%b cnt=%0d, expected 0 0", sound_alarm, snooze_cnt);
        end
    endtask

    task automatic test_simultaneous();
        start_ring();
        snooze_button = 1'b1;
        step();
        snooze_button = 1'b0;
        step();
        pulses(300);
        stop_button = 1'b1;
        snooze_button = 1'b1;
        step();
        n_checks++;
        if (sound_alarm !== 1'b0 || snoozing !== 1'b0 || snooze_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL stop_and_snooze: sound=%b snz=%b cnt=%0d, expected 0 0 0", sound_alarm, snoozing, snooze_cnt);
        end
        stop_button = 1'b0;
        snooze_button = 1'b0;
        step();
    endtask

    task automatic test_stop_no_rering();
        start_ring();
        press_stop();
        repeat (5) step();
        n_checks++;
        if (sound_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL no_rering_same_minute: sound=%b, expected 0", sound_alarm);
        end
        start_ring();
        n_checks++;
        if (sound_alarm !== 1'b1 || ring_start !== 1'b1) begin
            n_fail++;
            $display("FAIL rering_after_reload: sound=%b start=%b, expected 1 1", sound_alarm, ring_start);
        end
        press_stop();
    endtask

    task automatic test_level_hold();
        start_ring();
        stop_button = 1'b1;
        step();
        repeat (3) step();
        start_ring();
        n_checks++;
        if (sound_alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL held_stop: sound=%b, expected 1", sound_alarm);
        end
        stop_button = 1'b0;
        snooze_button = 1'b1;
        step();
        repeat (3) step();
        pulses(300);
        n_checks++;
        if (sound_alarm !== 1'b1 || snooze_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL held_snooze: sound=%b cnt=%0d, expected 1 1", sound_alarm, snooze_cnt);
        end
        snooze_button = 1'b0;
        step();
        press_stop();
    endtask

    task automatic test_enable();
        alarm_enable = 1'b0;
        step();
        step();
        alarm_enable = 1'b1;
        repeat (5) step();
        n_checks++;
        if (sound_alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_while_equal: sound=%b, expected 0", sound_alarm);
        end
        start_ring();
        snooze_button = 1'b1;
        step();
        snooze_button = 1'b0;
        alarm_enable = 1'b0;
        step();
        n_checks++;
        if (snoozing !== 1'b0 || sound_alarm !== 1'b0 || snooze_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL disable_in_snooze: snz=%b sound=%b cnt=%0d, expected 0 0 0", snoozing, sound_alarm, snooze_cnt);
        end
        alarm_enable = 1'b1;
        step();
    endtask

    task automatic test_reset_in_snooze();
        start_ring();
        snooze_button = 1'b1;
        step();
        snooze_button = 1'b0;
        step();
        pulses(300);
        snooze_button = 1'b1;
        step();
        snooze_button = 1'b0;
        n_checks++;
        if (snoozing !== 1'b1 || snooze_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL snooze_two: snz=%b cnt=%0d, expected 1 2", snoozing, snooze_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sound_alarm, snoozing, ring_start, snooze_cnt} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, expected 00000", {sound_alarm, snoozing, ring_start, snooze_cnt});
        end
        current_time = 16'h0729;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (sound_alarm !== 1'b0 || ring_start !== 1'b0 || snoozing !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: sound=%b start=%b snz=%b, expected 0 0 0", sound_alarm, ring_start, snoozing);
        end
        current_time = 16'h0730;
        step();
        n_checks++;
        if (sound_alarm !== 1'b1 || ring_start !== 1'b1) begin
            n_fail++;
            $display("FAIL armed_after_reset: sound=%b start=%b, expected 1 1", sound_alarm, ring_start);
        end
    endtask

    initial begin
        test_reset();
        test_match_ring();
        test_auto_stop();
        test_snooze_sequence();
        test_simultaneous();
        test_stop_no_rering();
        test_level_hold();
        test_enable();
        test_reset_in_snooze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 SHALL have parameter RING_SECS, default 60, the auto-stop ring duration in one_second pulses.
REQ-002 SHALL have parameter SNOOZE_SECS, default 300, the snooze duration in one_second pulses.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, the maximum number of snoozes per alarm event (1..3).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset; asynchronous, active-low.
REQ-006 SHALL have port one_second, input, 1 bit: a one-clk-wide pulse, once per second.
REQ-007 SHALL have port alarm_time, input, 16 bits: the stored alarm time, 4 BCD digits HH:MM.
REQ-008 SHALL have port current_time, input, 16 bits: the running clock time, 4 BCD digits HH:MM.
REQ-009 SHALL have port alarm_enable, input, 1 bit: a level; high arms the alarm.
REQ-010 SHALL have port stop_button, input, 1 bit: a level button.
REQ-011 SHALL have port snooze_button, input, 1 bit: a level button.
REQ-012 SHALL have port sound_alarm, output, 1 bit: high while ringing.
REQ-013 SHALL have port snoozing, output, 1 bit: high while in snooze.
REQ-014 SHALL have port ring_start, output, 1 bit: a 1-clk pulse on each entry to RINGING.
REQ-015 SHALL have port snooze_cnt, output, 2 bits: the number of snoozes used in the current alarm event.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, ARMED, RINGING, SNOOZE; sound_alarm = (state==RINGING); snoozing = (state==SNOOZE).
REQ-017 SHALL compute match = (current_time==alarm_time) and register it every cycle in all states into match_d.
REQ-018 SHALL define match_rise = match & ~match_d; only match_rise triggers an alarm, so the alarm rings at most once per minute of equality.
REQ-019 SHALL detect rising edges of stop_button and snooze_button with one-cycle registers; level holding SHALL NOT act more than once.
REQ-020 SHALL, in any state, go to IDLE on the next edge when alarm_enable=0, clearing sec_cnt and snooze_cnt; this rule has highest priority.
REQ-021 SHALL, in IDLE, go to ARMED when alarm_enable=1.
REQ-022 SHALL, in ARMED, go to RINGING on match_rise, with sec_cnt=0; ring_start SHALL be high for exactly the first cycle in RINGING.
REQ-023 SHALL, in RINGING, apply priority stop edge > snooze edge > timeout:
  - stop edge: go to ARMED, snooze_cnt=0.
  - snooze edge with snooze_cnt<MAX_SNOOZE: go to SNOOZE, snooze_cnt+1, sec_cnt=0.
  - snooze edge with snooze_cnt==MAX_SNOOZE: ignored.
  - one_second with sec_cnt==RING_SECS-1: go to ARMED, snooze_cnt=0.
  - otherwise: on one_second, sec_cnt+1.
REQ-024 SHALL, in SNOOZE, apply these rules:
  - stop edge: go to ARMED, snooze_cnt=0.
  - one_second with sec_cnt==SNOOZE_SECS-1: go to RINGING, sec_cnt=0, ring_start pulse.
  - snooze edge: ignored.
REQ-025 SHALL ignore match_rise in RINGING and SNOOZE.
REQ-026 SHALL size sec_cnt at 9 bits; it SHALL never exceed max(RING_SECS,SNOOZE_SECS)-1 and SHALL never wrap.
REQ-027 SHALL NOT generate match_rise when alarm_enable is raised while times are already equal, because match_d is already 1.
REQ-028 SHALL, when the time is set equal to alarm_time while ARMED, trigger RINGING through match_rise.

Reset
REQ-029 SHALL, while rst_n=0, immediately force:
  - state=IDLE, sec_cnt=0, snooze_cnt=0;
  - match_d=0, all button edge registers=0;
  - sound_alarm=0, snoozing=0, ring_start=0.
REQ-030 SHALL, on reset asserted mid-ring or mid-snooze, abort immediately with no residual pulse after release.
REQ-031 SHALL make the first state change after rst_n rises occur on a clk rising edge.

Verification
REQ-032 SHALL cover: enable=1, alarm_time=16'h0730, current_time steps 0729->0730 -> RINGING next clk, ring_start=1 for 1 clk, sound_alarm=1.
REQ-033 SHALL cover: ringing, no buttons, 60 one_second pulses -> ARMED after the 60th pulse, sound_alarm=0, snooze_cnt=0.
REQ-034 SHALL cover: ringing, snooze pressed 3 times with 300 s elapsing between presses -> snooze_cnt=1,2,3 and re-ring after each 300 s; 4th snooze press ignored, ringing continues.
REQ-035 SHALL cover: stop_button and snooze_button rising in the same clk during RINGING -> ARMED, snooze_cnt=0.
REQ-036 SHALL cover: ringing, stop pressed while current_time stays 0730 -> no re-ring; time 0731 then reloaded to 0730 -> rings again.
REQ-037 SHALL cover: rst_n=0 during SNOOZE with snooze_cnt=2 -> all outputs 0 asynchronously; after release state=IDLE, and alarm_enable=1 yields ARMED one clk later.
